// File: rtl/elevator_if.sv
`default_nettype none
// ============================================================================
//  Module   : elevator_if
//  Purpose  : Request buttons in, floor/door/status out, between the button
//             debouncer and the elevator controller.
//  Revision : 1.0  initial release
// ============================================================================
interface elevator_if;
   logic [3:0] req;
   logic [1:0] floorSel;
   logic       door;
   logic       moving;
   logic       dir_up;
   logic [3:0] pending;

   modport master (
      output req,
      input  floorSel, door, moving, dir_up, pending
   );

   modport slave (
      input  req,
      output floorSel, door, moving, dir_up, pending
   );
endinterface
`default_nettype wire

// File: rtl/elevator_controller.sv
`default_nettype none
// ============================================================================
//  Module   : elevator_controller
//  Purpose  : Four-floor sweep-order elevator: latches requests, travels one
//             floor per MOVE_CYCLES clocks, holds the door DOOR_CYCLES clocks.
//  Revision : 1.0  initial release
// ============================================================================
module elevator_controller #(
   parameter int MOVE_CYCLES = 4,
   parameter int DOOR_CYCLES = 6,
   parameter int CNT_W       = 8
) (
   input  wire logic   clk,
   input  wire logic   reset,
   elevator_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_MOVE_UP   = 2'd1,
      S_MOVE_DOWN = 2'd2,
      S_DOOR_OPEN = 2'd3
   } state_t;

   localparam logic [3:0]       c_ABOVE0   = 4'b1110;
   localparam logic [CNT_W-1:0] c_MOVE_END = CNT_W'(MOVE_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_DOOR_END = CNT_W'(DOOR_CYCLES - 1);

   state_t           r_state, w_state_nxt;
   logic [1:0]       r_floor, w_floor_nxt;
   logic [CNT_W-1:0] r_timer, w_timer_nxt;
   logic             r_dir_up, w_dir_up_nxt;
   logic [3:0]       r_pending, w_pending_nxt;
   logic             r_door, r_moving;

   logic [3:0] w_req_pend, w_here, w_above, w_below, w_serve;
   logic [1:0] w_floor_step;
   logic [3:0] w_here_step, w_ahead_step;
   logic       w_going_up, w_at_limit;

   assign w_req_pend   = r_pending | bus.req;
   assign w_here       = 4'b0001 << r_floor;
   assign w_above      = c_ABOVE0 << r_floor;
   assign w_below      = ~(w_above | w_here);

   // Arrival-floor view used on the edge that completes one floor of travel
   assign w_going_up   = (r_state == S_MOVE_UP);
   assign w_at_limit   = w_going_up ? (r_floor == 2'd3) : (r_floor == 2'd0);
   assign w_floor_step = w_going_up ? (r_floor + 2'd1) : (r_floor - 2'd1);
   assign w_here_step  = 4'b0001 << w_floor_step;
   assign w_ahead_step = w_going_up ? (c_ABOVE0 << w_floor_step)
                                    : ~((c_ABOVE0 << w_floor_step) | w_here_step);

   always_comb begin
      w_state_nxt  = r_state;
      w_floor_nxt  = r_floor;
      w_timer_nxt  = r_timer;
      w_dir_up_nxt = r_dir_up;
      w_serve      = 4'b0000;

      case (r_state)
         S_IDLE: begin
            w_timer_nxt = '0;
            // Direction flips only when work waits behind; an empty building keeps the last sweep
            if (|(w_req_pend & w_here)) begin
               w_state_nxt = S_DOOR_OPEN;
            end else if (r_dir_up && |(r_pending & w_above)) begin
               w_state_nxt = S_MOVE_UP;
            end else if (!r_dir_up && |(r_pending & w_below)) begin
               w_state_nxt = S_MOVE_DOWN;
            end else if (|(r_pending & w_above)) begin
               w_state_nxt  = S_MOVE_UP;
               w_dir_up_nxt = 1'b1;
            end else if (|(r_pending & w_below)) begin
               w_state_nxt  = S_MOVE_DOWN;
               w_dir_up_nxt = 1'b0;
            end
         end

         S_MOVE_UP, S_MOVE_DOWN: begin
            if (w_at_limit) begin
               w_state_nxt = S_IDLE;
               w_timer_nxt = '0;
            end else if (r_timer == c_MOVE_END) begin
               w_timer_nxt = '0;
               w_floor_nxt = w_floor_step;
               if (|(w_req_pend & w_here_step))
                  w_state_nxt = S_DOOR_OPEN;
               else if (!(|(w_req_pend & w_ahead_step)))
                  w_state_nxt = S_IDLE;
            end else begin
               w_timer_nxt = r_timer + 1'b1;
            end
         end

         S_DOOR_OPEN: begin
            if (bus.req[r_floor]) begin
               w_timer_nxt = '0;
            end else if (r_timer == c_DOOR_END) begin
               w_state_nxt = S_IDLE;
               w_timer_nxt = '0;
            end else begin
               w_timer_nxt = r_timer + 1'b1;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = '0;
         end
      endcase

      if (w_state_nxt == S_DOOR_OPEN)
         w_serve = 4'b0001 << w_floor_nxt;
      if (r_state == S_DOOR_OPEN)
         w_serve = w_serve | w_here;
      w_pending_nxt = w_req_pend & ~w_serve;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_floor   <= 2'd0;
         r_timer   <= '0;
         r_dir_up  <= 1'b1;
         r_pending <= 4'b0000;
         r_door    <= 1'b0;
         r_moving  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_floor   <= w_floor_nxt;
         r_timer   <= w_timer_nxt;
         r_dir_up  <= w_dir_up_nxt;
         r_pending <= w_pending_nxt;
         r_door    <= (w_state_nxt == S_DOOR_OPEN);
         r_moving  <= (w_state_nxt == S_MOVE_UP) || (w_state_nxt == S_MOVE_DOWN);
      end
   end

   assign bus.floorSel = r_floor;
   assign bus.door     = r_door;
   assign bus.moving   = r_moving;
   assign bus.dir_up   = r_dir_up;
   assign bus.pending  = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_elevator_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_elevator_controller
//  Purpose  : Directed tables, corner sequences and random requests checked
//             against a floor/countdown reference model of the elevator.
//  Revision : 1.0  initial release
// ============================================================================
module tb_elevator_controller;
   localparam int MOVE_CYCLES = 4;
   localparam int DOOR_CYCLES = 6;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   elevator_if bus ();

   always #5 clk = ~clk;

   elevator_controller #(
      .MOVE_CYCLES (MOVE_CYCLES),
      .DOOR_CYCLES (DOOR_CYCLES),
      .CNT_W       (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a position, a travel direction, and two countdowns
   int       m_floor, m_dir, m_door_left, m_travel_left;
   bit [3:0] m_pend;

   typedef struct {
      logic [3:0] req;
      int         reps;
      logic [1:0] fl;
      bit         door;
      bit         mov;
      bit         dir;
      logic [3:0] pend;
   } vec_t;
   vec_t tbl[$];

   function automatic bit ahead(bit [3:0] p, int f, int d);
      for (int k = f + d; k >= 0 && k < 4; k += d)
         if (p[k]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [8:0] model_out();
      return {m_floor[1:0], m_door_left > 0, m_travel_left > 0, m_dir > 0, m_pend};
   endfunction

   function automatic logic [8:0] dut_out();
      return {bus.floorSel, bus.door, bus.moving, bus.dir_up, bus.pending};
   endfunction

   task automatic model_reset();
      m_floor = 0; m_dir = 1; m_pend = 4'b0000; m_door_left = 0; m_travel_left = 0;
   endtask

   task automatic model_step(input bit [3:0] r);
      bit [3:0] p2, here;
      p2   = m_pend | r;
      here = 4'(1 << m_floor);
      if (m_door_left > 0) begin
         m_door_left = r[m_floor] ? DOOR_CYCLES : m_door_left - 1;
         m_pend      = p2 & ~here;
      end else if (m_travel_left > 0) begin
         m_travel_left--;
         if (m_travel_left == 0) begin
            m_floor = m_floor + m_dir;
            here    = 4'(1 << m_floor);
            if ((p2 & here) != 0) begin
               m_door_left = DOOR_CYCLES;
               m_pend      = p2 & ~here;
            end else begin
               m_pend = p2;
               if (ahead(p2, m_floor, m_dir)) m_travel_left = MOVE_CYCLES;
            end
         end else begin
            m_pend = p2;
         end
      end else begin
         if ((p2 & here) != 0) begin
            m_door_left = DOOR_CYCLES;
            m_pend      = p2 & ~here;
         end else begin
            if (ahead(m_pend, m_floor, m_dir)) begin
               m_travel_left = MOVE_CYCLES;
            end else if (ahead(m_pend, m_floor, -m_dir)) begin
               m_dir         = -m_dir;
               m_travel_left = MOVE_CYCLES;
            end
            m_pend = p2;
         end
      end
   endtask

   task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %b, expected %b", name, $time, got, exp);
      end
   endtask

   task automatic step(input logic [3:0] r);
      bus.req = r;
      @(posedge clk);
      model_step(r);
      #1;
      check("model", dut_out(), model_out());
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset   = 1'b1;
      bus.req = 4'b0000;
      #1;
      model_reset();
      check("reset_state", dut_out(), 9'b00_0_0_1_0000);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_door(input bit want, input string name);
      int k = 0;
      while (bus.door !== want && k < 100) begin
         step(4'b0000);
         k++;
      end
      check(name, 9'(bus.door), 9'(want));
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.req = 4'b0000;
      model_reset();

      // Reset held, then released
      repeat (3) @(posedge clk);
      #1 check("reset_held", dut_out(), 9'b00_0_0_1_0000);
      @(negedge clk);
      reset = 1'b0;
      #1 check("reset_released", dut_out(), 9'b00_0_0_1_0000);

      // Door cycle at floor 0, then a full up-sweep to floor 3
      tbl.push_back(vec_t'{4'b0001, 1, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0000});
      tbl.push_back(vec_t'{4'b0000, 5, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0000});
      tbl.push_back(vec_t'{4'b0000, 1, 2'd0, 1'b0, 1'b0, 1'b1, 4'b0000});
      tbl.push_back(vec_t'{4'b1000, 1, 2'd0, 1'b0, 1'b0, 1'b1, 4'b1000});
      tbl.push_back(vec_t'{4'b0000, 4, 2'd0, 1'b0, 1'b1, 1'b1, 4'b1000});
      tbl.push_back(vec_t'{4'b0000, 4, 2'd1, 1'b0, 1'b1, 1'b1, 4'b1000});
      tbl.push_back(vec_t'{4'b0000, 4, 2'd2, 1'b0, 1'b1, 1'b1, 4'b1000});
      tbl.push_back(vec_t'{4'b0000, 1, 2'd3, 1'b1, 1'b0, 1'b1, 4'b0000});
      tbl.push_back(vec_t'{4'b0000, 5, 2'd3, 1'b1, 1'b0, 1'b1, 4'b0000});
      tbl.push_back(vec_t'{4'b0000, 1, 2'd3, 1'b0, 1'b0, 1'b1, 4'b0000});
      foreach (tbl[i]) begin
         for (int k = 0; k < tbl[i].reps; k++) begin
            step(k == 0 ? tbl[i].req : 4'b0000);
            check($sformatf("tbl[%0d]", i), dut_out(),
                  {tbl[i].fl, tbl[i].door, tbl[i].mov, tbl[i].dir, tbl[i].pend});
         end
      end

      // Two requests in one pulse: stop at 1, keep 3 pending, continue up
      do_reset();
      step(4'b1010);
      wait_door(1'b1, "t4_open1");
      check("t4_floor1_pend", 9'({bus.floorSel, bus.pending}), 9'({2'd1, 4'b1000}));
      wait_door(1'b0, "t4_close1");
      wait_door(1'b1, "t4_open3");
      check("t4_floor3", 9'({bus.floorSel, bus.dir_up}), 9'({2'd3, 1'b1}));

      // Request behind the car while sweeping up is served on the way down
      do_reset();
      step(4'b1000);
      n = 0;
      while (bus.floorSel != 2'd2 && n < 40) begin
         step(4'b0000);
         n++;
      end
      check("t5_reach2", 9'(bus.floorSel), 9'd2);
      step(4'b0001);
      wait_door(1'b1, "t5_open3");
      check("t5_floor3", 9'(bus.floorSel), 9'd3);
      wait_door(1'b0, "t5_close3");
      wait_door(1'b1, "t5_open0");
      check("t5_floor0_down", 9'({bus.floorSel, bus.dir_up}), 9'({2'd0, 1'b0}));

      // Re-press while open restarts the door, then reset mid-move
      do_reset();
      step(4'b0010);
      wait_door(1'b1, "t6_open1");
      repeat (3) step(4'b0000);
      step(4'b0010);
      n = 0;
      while (bus.door && n < 20) begin
         step(4'b0000);
         n++;
      end
      check("t6_restart_len", 9'(n), 9'(DOOR_CYCLES));
      step(4'b1000);
      step(4'b0000);
      step(4'b0100);
      check("t6_moving", 9'(bus.moving), 9'd1);
      #2 reset = 1'b1;
      #1 check("t6_async_reset", dut_out(), 9'b00_0_0_1_0000);
      model_reset();
      @(negedge clk);
      reset = 1'b0;

      // Random request traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 599) == 0)
            do_reset();
         else if ($urandom_range(0, 7) == 0)
            step(4'($urandom_range(1, 15)));
         else
            step(4'b0000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
